// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiply and restoring divide into HI/LO.
// Define MULTDIV_UNSIGNED_EN to add the unsigned_op port (multu/divu semantics).
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  // Accumulator layout: {upper (WIDTH+1), lower (WIDTH), booth bit}
  localparam int unsigned AW = 2 * WIDTH + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MULT   = 2'd1;
  localparam logic [1:0] S_DIV    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   opb_q, opb_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             uns_q, uns_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             op_uns_c;
  logic             a_neg_in_c, b_neg_in_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   booth_up_c, booth_sum_c;
  logic [WIDTH:0]   div_sh_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_rem_c;
  logic [WIDTH-1:0] q_res_c, r_res_c;

`ifdef MULTDIV_UNSIGNED_EN
  assign op_uns_c = unsigned_op;
`else
  assign op_uns_c = 1'b0;
`endif

  // Operand sign and magnitude for the divider; unsigned mode treats operands as non-negative
  assign a_neg_in_c = ~op_uns_c & a[WIDTH-1];
  assign b_neg_in_c = ~op_uns_c & b[WIDTH-1];
  assign a_mag_c    = a_neg_in_c ? (~a + WIDTH'(1)) : a;
  assign b_mag_c    = b_neg_in_c ? (~b + WIDTH'(1)) : b;

  // Next-state, datapath step and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    uns_d       = uns_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dz_d        = 1'b0;
    booth_up_c  = acc_q[AW-1 -: WIDTH+1];
    booth_sum_c = booth_up_c;
    div_sh_c    = {acc_q[2*WIDTH:WIDTH+1], acc_q[WIDTH]};
    div_ge_c    = 1'b0;
    div_rem_c   = div_sh_c[WIDTH-1:0];
    q_res_c     = acc_q[WIDTH:1];
    r_res_c     = acc_q[2*WIDTH:WIDTH+1];

    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d = S_MULT;
          cnt_d   = '0;
          acc_d   = {{(WIDTH+1){1'b0}}, b, 1'b0};
          opb_d   = {a[WIDTH-1] & ~op_uns_c, a};
          a_neg_d = 1'b0;
          b_neg_d = b[WIDTH-1];
          uns_d   = op_uns_c;
        end else if (start_div) begin
          state_d = S_DIV;
          cnt_d   = '0;
          acc_d   = {{(WIDTH+1){1'b0}}, a_mag_c, 1'b0};
          opb_d   = {1'b0, b_mag_c};
          a_neg_d = a_neg_in_c;
          b_neg_d = b_neg_in_c;
          uns_d   = op_uns_c;
        end
      end

      S_MULT: begin
        if (cnt_q == CW'(WIDTH)) begin
          // Unsigned product = signed({0,a} * b) + (a << WIDTH) when b's msb is set
          state_d = S_FINISH;
          done_d  = 1'b1;
          hi_d    = booth_up_c[WIDTH-1:0] + ((uns_q & b_neg_q) ? opb_q[WIDTH-1:0] : '0);
          lo_d    = acc_q[WIDTH:1];
        end else begin
          case (acc_q[1:0])
            2'b10:   booth_sum_c = booth_up_c - opb_q;
            2'b01:   booth_sum_c = booth_up_c + opb_q;
            default: booth_sum_c = booth_up_c;
          endcase
          acc_d = {booth_sum_c[WIDTH], booth_sum_c, acc_q[WIDTH:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DIV: begin
        if (opb_q == '0) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end else if (cnt_q == CW'(WIDTH)) begin
          // Quotient negated on sign mismatch; remainder follows the dividend
          state_d = S_FINISH;
          done_d  = 1'b1;
          lo_d    = (a_neg_q ^ b_neg_q) ? (~q_res_c + WIDTH'(1)) : q_res_c;
          hi_d    = a_neg_q ? (~r_res_c + WIDTH'(1)) : r_res_c;
        end else begin
          div_ge_c = (div_sh_c >= opb_q);
          if (div_ge_c) begin
            div_rem_c = WIDTH'(div_sh_c - opb_q);
          end
          acc_d = {1'b0, div_rem_c, acc_q[WIDTH-1:1], div_ge_c, 1'b0};
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      uns_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      uns_q   <= uns_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;
`ifdef MULTDIV_UNSIGNED_EN
  logic        unsigned_op = 1'b0;
`endif

  int checks = 0;
  int passes = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
`ifdef MULTDIV_UNSIGNED_EN
    .unsigned_op(unsigned_op),
`endif
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Reference model: an accepted op keeps the unit busy 34 cycles (2 for divide-by-zero);
  // results appear in the last busy cycle together with done.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_dz = 1'b0, m_uns;
  logic [63:0] m_prod;
  longint      m_sa, m_sb, m_q, m_r;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1 && !p_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start_mult || start_div) begin
      m_uns = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
      m_uns = unsigned_op;
`endif
      m_sa = m_uns ? longint'({32'h0, a}) : longint'($signed(a));
      m_sb = m_uns ? longint'({32'h0, b}) : longint'($signed(b));
      p_dz = 1'b0;
      if (start_mult) begin
        m_prod = 64'(m_sa * m_sb);
        p_hi   = m_prod[63:32];
        p_lo   = m_prod[31:0];
        m_left = 34;
      end else if (b == 32'h0) begin
        p_dz   = 1'b1;
        m_left = 2;
      end else begin
        m_q    = m_sa / m_sb;
        m_r    = m_sa % m_sb;
        p_lo   = 32'(m_q);
        p_hi   = 32'(m_r);
        m_left = 34;
      end
    end
  end

  always @(negedge clock) begin
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_left == 1));
    check("div_zero", 32'(div_zero), 32'(m_left == 1 && p_dz));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  // Issue one op at a negedge, wait for done (bounded), check latency and literal results.
  task automatic do_op(input string name, input logic sm, input logic sd,
                       input logic [31:0] ta, input logic [31:0] tb_v, input int lat,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int stray);
    int  k;
    bit  got;
    start_mult = sm;
    start_div  = sd;
    a          = ta;
    b          = tb_v;
    @(posedge clock);
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
    got = 1'b0;
    for (k = 1; k <= 40; k++) begin
      if (k == stray) start_div = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start_div = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_latency"}, 32'(k), 32'(lat));
      check({name, "_hi"}, hi, ehi);
      check({name, "_lo"}, lo, elo);
      check({name, "_dz"}, 32'(div_zero), 32'(edz));
    end
    @(posedge clock);
    @(negedge clock);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  int done_cnt;

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    do_op("mul_7_m3",   1, 0, 32'd7,          32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    do_op("div_m7_2",   0, 1, 32'hFFFFFFF9,   32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    do_op("div_100_m7", 0, 1, 32'd100,        32'hFFFFFFF9, 33, 32'h00000002, 32'hFFFFFFF2, 0, 0);
    do_op("div_ovf",    0, 1, 32'h80000000,   32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 0, 0);
    do_op("div_zero",   0, 1, 32'd5,          32'h0,        1,  32'h00000000, 32'h80000000, 1, 0);
    do_op("both_start", 1, 1, 32'h00010000,   32'h00010000, 33, 32'h00000001, 32'h00000000, 0, 5);
    do_op("mul_minmin", 1, 0, 32'h80000000,   32'h80000000, 33, 32'h40000000, 32'h00000000, 0, 0);
    do_op("mul_m1_m1",  1, 0, 32'hFFFFFFFF,   32'hFFFFFFFF, 33, 32'h00000000, 32'h00000001, 0, 0);
    do_op("mul_mixed",  1, 0, 32'd12345,      32'hFFFFFC18, 33, 32'hFFFFFFFF, 32'hFF43A158, 0, 0);

    // Abort a multiply with reset after edge E10
    start_mult = 1'b1;
    a = 32'd1234;
    b = 32'd5678;
    @(posedge clock);
    @(negedge clock);
    start_mult = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    do_op("div_after_rst", 0, 1, 32'd1000, 32'd7, 33, 32'h00000006, 32'h0000008E, 0, 0);

`ifdef MULTDIV_UNSIGNED_EN
    unsigned_op = 1'b1;
    do_op("mulu_max", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 0, 0);
    do_op("divu_max", 0, 1, 32'hFFFFFFFF, 32'd2,        33, 32'h00000001, 32'h7FFFFFFF, 0, 0);
    do_op("divu_zero", 0, 1, 32'd9,       32'h0,        1,  32'h00000001, 32'h7FFFFFFF, 1, 0);
    unsigned_op = 1'b0;
`endif

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide datapath block, directly downstream of the main control unit FSM.
- Control asserts a one-cycle start while A/B hold rs/rt operands. The block iterates and writes the 64-bit result into HI/LO.
- Control stalls in a wait state until done, then reads HI/LO for mfhi/mflo.
- Also flags division by zero so control can raise an exception through EPC.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start_mult  in  1  one-cycle request: signed multiply a*b.
- start_div  in  1  one-cycle request: signed divide a/b.
- a  in  WIDTH  operand A (dividend / multiplicand), sampled at the accepting edge.
- b  in  WIDTH  operand B (divisor / multiplier), sampled at the accepting edge.
- hi  out  WIDTH  product upper half, or division remainder.
- lo  out  WIDTH  product lower half, or division quotient.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse when hi/lo are valid.
- div_zero  out  1  one-cycle pulse with done when divisor was 0.

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Reset mid-operation aborts with no hi/lo update.
- States: IDLE, MULT, DIV, FINISH.
- IDLE: start is accepted only in IDLE; start_* asserted while busy is ignored.
  - start_mult and start_div together: multiply wins.
  - On accepting edge E0: latch a, b, counter=0, go to MULT or DIV.
  - start_div with b==0: go to FINISH directly. hi/lo are left unchanged, and div_zero=1 together with done=1 in the FINISH cycle.
- MULT: radix-2 Booth on a 2*WIDTH+1 accumulator, one step per cycle. Edges E1..E32 perform 32 steps; after the 32nd step, go to FINISH.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle (E1..E32), then FINISH.
  - Sign fix applied when writing results: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Quotient truncates toward zero.
  - -2^31 / -1: lo=0x80000000 (wraps), hi=0.
- FINISH: hi/lo are registered on entry, so they update at edge E33 (E1 for divide-by-zero). done=1 for exactly that one cycle. Next edge returns to IDLE.
- busy=1 in MULT, DIV and FINISH.
- Multiply result: {hi,lo} = full 64-bit two's-complement product; no overflow flag.
- hi/lo hold their value between operations; they change only in FINISH or on reset.
- Start in the cycle after FINISH (state IDLE) is accepted normally; back-to-back issue interval is 34 cycles.

Optional Feature:
- MULTDIV_UNSIGNED_EN defined: adds input port unsigned_op (1 bit), sampled with start.
  - When 1: multu/divu semantics. Operands are zero-extended, there is no sign fix, and 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.
  - Divide-by-zero handling is identical to signed mode.
- Not defined: the port does not exist and all operations are signed.

Test Plan:
- Reset during MULT at cycle 10 -> hi=lo=0, busy=0 immediately; no done pulse afterwards.
- start_mult, a=7, b=-3 -> done at E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high E1..E33.
- start_div, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- start_div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then start_div with a=5, b=0 -> done and div_zero at E1, hi/lo unchanged.
- start_mult and start_div asserted together (a=0x10000, b=0x10000) -> multiply performed, hi=1, lo=0. A start_div pulsed at E5 is ignored.
- With MULTDIV_UNSIGNED_EN: unsigned_op=1, a=b=0xFFFFFFFF, start_mult -> hi=0xFFFFFFFE, lo=0x00000001.
